// File: rtl/image_engine.sv
`default_nettype none
// image_engine: in-place vertical/horizontal mirror, grayscale or invert over an IMG_H x IMG_W RGB frame buffer.
// Rev 1.0 -- shared row/col address, one-cycle-latency read port, registered write port.
module image_engine #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CH_W  = 8,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [3*CH_W-1:0] in_pix,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              out_we,
  output logic [3*CH_W-1:0] out_pix,
  output logic              busy,
  output logic              done
);

  localparam int PIX_W = 3 * CH_W;
  localparam logic [COL_W-1:0] W_MAX      = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] W_HALF_END = COL_W'(IMG_W / 2 - 1);
  localparam logic [ROW_W-1:0] H_MAX      = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] H_HALF_END = ROW_W'(IMG_H / 2 - 1);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP, WR_A, WR_B, DONE} state_t;

  state_t             state;
  logic [1:0]         op;
  logic [ROW_W-1:0]   r_idx;
  logic [COL_W-1:0]   c_idx;
  logic [PIX_W-1:0]   pix_a;

  logic               mirror;
  logic [ROW_W-1:0]   b_row;
  logic [COL_W-1:0]   b_col;
  logic               c_wrap;
  logic               last;
  logic [ROW_W-1:0]   next_r;
  logic [COL_W-1:0]   next_c;
  logic [CH_W-1:0]    ch_r, ch_g, ch_b, mx, mn;
  logic [CH_W:0]      gsum;
  logic [PIX_W-1:0]   f_pix;

  // Partner address and loop bounds depend on the latched operation.
  always_comb begin
    mirror = ~op[1];
    b_row  = (op == 2'd0) ? H_MAX - r_idx : r_idx;
    b_col  = (op == 2'd1) ? W_MAX - c_idx : c_idx;
    c_wrap = (c_idx == ((op == 2'd1) ? W_HALF_END : W_MAX));
    last   = c_wrap && (r_idx == ((op == 2'd0) ? H_HALF_END : H_MAX));
    next_c = c_wrap ? '0 : c_idx + COL_W'(1);
    next_r = c_wrap ? r_idx + ROW_W'(1) : r_idx;
  end

  // Grayscale midpoint of the channel range; the extra sum bit keeps the carry.
  always_comb begin
    ch_r = in_pix[3*CH_W-1 -: CH_W];
    ch_g = in_pix[2*CH_W-1 -: CH_W];
    ch_b = in_pix[CH_W-1:0];
    mx = ch_r;
    mn = ch_r;
    if (ch_g > mx) mx = ch_g;
    if (ch_b > mx) mx = ch_b;
    if (ch_g < mn) mn = ch_g;
    if (ch_b < mn) mn = ch_b;
    gsum  = {1'b0, mx} + {1'b0, mn};
    f_pix = (op == 2'd2) ? {3{gsum[CH_W:1]}} : ~in_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= 2'd0;
      r_idx   <= '0;
      c_idx   <= '0;
      pix_a   <= '0;
      row     <= '0;
      col     <= '0;
      out_we  <= 1'b0;
      out_pix <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      out_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op    <= mode;
            busy  <= 1'b1;
            r_idx <= '0;
            c_idx <= '0;
            row   <= '0;
            col   <= '0;
            state <= RD_A;
          end
        end
        RD_A: begin
          if (mirror) begin
            row   <= b_row;
            col   <= b_col;
            state <= RD_B;
          end else begin
            state <= CAP;
          end
        end
        RD_B: begin
          pix_a <= in_pix;
          state <= CAP;
        end
        CAP: begin
          out_we <= 1'b1;
          state  <= WR_A;
          if (mirror) begin
            row     <= r_idx;
            col     <= c_idx;
            out_pix <= in_pix;
          end else begin
            out_pix <= f_pix;
          end
        end
        WR_A, WR_B: begin
          if (state == WR_A && mirror) begin
            row     <= b_row;
            col     <= b_col;
            out_we  <= 1'b1;
            out_pix <= pix_a;
            state   <= WR_B;
          end else if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            r_idx <= next_r;
            c_idx <= next_c;
            row   <= next_r;
            col   <= next_c;
            state <= RD_A;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
